// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the collector state encoding.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/bit_idx_cnt.sv
// Bit index counter: counts accepted bits modulo WIDTH, with synchronous clear.
module bit_idx_cnt #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] r_idx;

    // Clear wins over increment; increment wraps to 0 after the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/bit_deser_32.sv
// Serial-to-parallel collector: gathers WIDTH bits MSB-first and presents the
// word on a valid/ready port. Bit accepted at index k lands in word bit WIDTH-1-k.
module bit_deser_32 #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [IDX_W-1:0] bit_idx
);

    import alu_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_pos;
    logic [WIDTH-1:0] w_merged;
    logic             w_bit_ready;
    logic             w_accept;
    logic             w_complete;

    // A pending word blocks input unless it is being consumed this cycle.
    assign w_bit_ready = (r_state == ST_FILL) | word_ready;
    // Flush drops a same-cycle bit.
    assign w_accept    = bit_valid & w_bit_ready & ~flush;
    assign w_complete  = w_accept & (w_idx == LAST);
    assign w_pos       = LAST - w_idx;

    bit_idx_cnt #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_accept),
        .o_idx (w_idx)
    );

    // Partial word with the incoming bit merged at its MSB-first position.
    always_comb begin
        w_merged        = r_partial;
        w_merged[w_pos] = bit_in;
    end

    // Partial word register: cleared on flush and on word completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_partial <= '0;
        end else if (flush || w_complete) begin
            r_partial <= '0;
        end else if (w_accept) begin
            r_partial <= w_merged;
        end
    end

    // Output FSM: loads completed words and holds them until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_complete) begin
                        r_word       <= w_merged;
                        r_word_valid <= 1'b1;
                        r_state      <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A completing accept can only happen here with word_ready high,
                    // so the old word is consumed and the new one replaces it.
                    if (w_complete) begin
                        r_word <= w_merged;
                    end else if (word_ready) begin
                        r_word_valid <= 1'b0;
                        r_state      <= ST_FILL;
                    end
                end
                default: begin
                    r_word_valid <= 1'b0;
                    r_state      <= ST_FILL;
                end
            endcase
        end
    end

    assign bit_ready  = w_bit_ready;
    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign bit_idx    = w_idx;

endmodule
